// File: rtl/fft_seq_ctrl_if.sv
// Handshake and memory-control bundle of the FFT sequencer.
// slave  : seen by fft_seq_ctrl (inputs start/inverse/in_valid/out_ready, drives the rest)
// master : seen by the environment driving the sequencer
interface fft_seq_ctrl_if #(
  parameter int unsigned LOG2N = 4
);
  localparam int unsigned SW = (LOG2N > 2) ? $clog2(LOG2N) : 1;

  logic             start;
  logic             inverse;
  logic             in_valid;
  logic             in_ready;
  logic             ld_wr_en;
  logic [LOG2N-1:0] ld_addr;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic [LOG2N-2:0] tw_addr;
  logic             tw_conj;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_a;
  logic [LOG2N-1:0] wr_addr_b;
  logic [SW-1:0]    stage;
  logic             out_valid;
  logic             out_ready;
  logic [LOG2N-1:0] out_addr;
  logic             busy;
  logic             done;

  modport master (
    output start, inverse, in_valid, out_ready,
    input  in_ready, ld_wr_en, ld_addr, rd_en, rd_addr_a, rd_addr_b, tw_addr, tw_conj,
           wr_en, wr_addr_a, wr_addr_b, stage, out_valid, out_addr, busy, done
  );

  modport slave (
    input  start, inverse, in_valid, out_ready,
    output in_ready, ld_wr_en, ld_addr, rd_en, rd_addr_a, rd_addr_b, tw_addr, tw_conj,
           wr_en, wr_addr_a, wr_addr_b, stage, out_valid, out_addr, busy, done
  );
endinterface

// File: rtl/fft_seq_ctrl.sv
// In-place radix-2 FFT sequencer: bit-reversed load, LOG2N butterfly stages
// with a D-cycle drain gap between them, natural-order unload.
// Ports: clk, rst (sync, active-high), bus (fft_seq_ctrl_if.slave).
module fft_seq_ctrl #(
  parameter int unsigned LOG2N  = 4,
  parameter int unsigned BF_LAT = 3
) (
  input  logic          clk,
  input  logic          rst,
  fft_seq_ctrl_if.slave bus
);
  localparam int unsigned N    = 1 << LOG2N;
  localparam int unsigned D    = 1 + BF_LAT;
  localparam int unsigned SW   = (LOG2N > 2) ? $clog2(LOG2N) : 1;
  localparam int unsigned AW   = LOG2N;
  localparam int unsigned JW   = LOG2N - 1;
  localparam int unsigned CW   = LOG2N + 1;
  localparam int unsigned GW   = $clog2(D + 1);
  localparam int unsigned SMAX = LOG2N - 1;

  typedef enum logic [2:0] {IDLE, LOAD, CALC, GAP, UNLOAD} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [JW-1:0] j_q, j_d;
  logic [SW-1:0] s_q, s_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          mode_q, mode_d;
  logic          done_q, done_d;

  logic          in_ready_c, ld_wr_en_c, rd_en_c, tw_conj_c, out_valid_c;
  logic [AW-1:0] ld_addr_c, ra_c, rb_c, out_addr_c;
  logic [JW-1:0] tw_c;
  logic [SW-1:0] stage_c;
  logic [AW-1:0] span, jx, kx, ax, tw_full, rev;

  // Read-to-write delay line (memory read + butterfly pipeline)
  logic [D-1:0]  dv_q;
  logic [AW-1:0] da_q [D];
  logic [AW-1:0] db_q [D];

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      j_q     <= '0;
      s_q     <= '0;
      gap_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      s_q     <= s_d;
      gap_q   <= gap_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    j_d     = j_q;
    s_d     = s_q;
    gap_d   = gap_q;
    mode_d  = mode_q;
    done_d  = 1'b0;

    in_ready_c  = 1'b0;
    ld_wr_en_c  = 1'b0;
    ld_addr_c   = '0;
    rd_en_c     = 1'b0;
    ra_c        = '0;
    rb_c        = '0;
    tw_c        = '0;
    tw_conj_c   = 1'b0;
    stage_c     = '0;
    out_valid_c = 1'b0;
    out_addr_c  = '0;

    for (int i = 0; i < int'(AW); i++) rev[i] = cnt_q[int'(AW) - 1 - i];

    // Butterfly j of stage s: group bits of j move up one place, span bit inserted as 0/1
    span    = AW'(1) << s_q;
    jx      = AW'(j_q);
    kx      = jx & (span - AW'(1));
    ax      = ((jx & ~(span - AW'(1))) << 1) | kx;
    tw_full = kx << (SMAX - 32'(s_q));

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d  = bus.inverse;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          ld_wr_en_c = 1'b1;
          ld_addr_c  = rev;
          cnt_d      = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            s_d     = '0;
            j_d     = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rd_en_c   = 1'b1;
        ra_c      = ax;
        rb_c      = ax | span;
        tw_c      = tw_full[JW-1:0];
        tw_conj_c = mode_q;
        stage_c   = s_q;
        j_d       = j_q + JW'(1);
        if (j_q == JW'(N / 2 - 1)) begin
          j_d     = '0;
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        stage_c = s_q;
        gap_d   = gap_q + GW'(1);
        if (gap_q == GW'(D - 1)) begin
          j_d = '0;
          if (s_q == SW'(SMAX)) begin
            cnt_d   = '0;
            state_d = UNLOAD;
          end else begin
            s_d     = s_q + SW'(1);
            state_d = CALC;
          end
        end
      end
      UNLOAD: begin
        out_valid_c = 1'b1;
        out_addr_c  = cnt_q[AW-1:0];
        if (bus.out_ready) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Delay line: idle slots carry valid=0 and zero addresses
  always_ff @(posedge clk) begin
    if (rst) begin
      dv_q <= '0;
      for (int i = 0; i < int'(D); i++) begin
        da_q[i] <= '0;
        db_q[i] <= '0;
      end
    end else begin
      dv_q[0] <= rd_en_c;
      da_q[0] <= ra_c;
      db_q[0] <= rb_c;
      for (int i = 1; i < int'(D); i++) begin
        dv_q[i] <= dv_q[i-1];
        da_q[i] <= da_q[i-1];
        db_q[i] <= db_q[i-1];
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.ld_wr_en  = ld_wr_en_c;
  assign bus.ld_addr   = ld_addr_c;
  assign bus.rd_en     = rd_en_c;
  assign bus.rd_addr_a = ra_c;
  assign bus.rd_addr_b = rb_c;
  assign bus.tw_addr   = tw_c;
  assign bus.tw_conj   = tw_conj_c;
  assign bus.wr_en     = dv_q[D-1];
  assign bus.wr_addr_a = da_q[D-1];
  assign bus.wr_addr_b = db_q[D-1];
  assign bus.stage     = stage_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_addr  = out_addr_c;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
endmodule
